pipe_phy_ctrl_responder: RTL and testbench
==========================================

Name: pipe_phy_ctrl_responder

Overview:
PHY-side control responder for the PIPE interface. It answers MAC requests with the PhyStatus and RxStatus handshake:
- reset completion
- PowerDown transitions
- Rate changes
- receiver detection

It sits opposite the MAC's PIPE control outputs and is used as a synthesizable PHY stand-in beside the data-path models.

Parameters:
RESET_DLY, 64, cycles PhyStatus stays high after reset deassertion
PD_DLY, 16, cycles from accepted PowerDown change to PhyStatus pulse
RATE_DLY, 32, cycles from accepted Rate change to PhyStatus pulse
DETECT_DLY, 24, cycles from accepted TxDetectRx to PhyStatus pulse
MAX_RATE, 4, highest legal Rate encoding (0=Gen1 .. 4=Gen5)

Ports:
clk  in  1  PIPE clock; the single clock of the block
reset  in  1  asynchronous, active-low reset
Powerdown  in  4  requested power state: 0=P0, 1=P0s, 2=P1, 3=P2, others reserved
Rate  in  4  requested rate encoding
TxDetectRx  in  1  receiver-detect request / loopback request
TxEelecIdle  in  4  per-lane TX electrical idle; bit0 governs detection
rx_present  in  1  environment: far-end receiver present
PhyStatus  out  1  completion handshake
RxStatus  out  3  status code; 3'b011 = receiver detected
RxElecidle  out  1  RX electrical idle indication
cur_pd  out  4  currently active power state
cur_rate  out  4  currently active rate
req_err  out  1  one-cycle pulse on a reserved/illegal request

Behaviour:
Reset values (reset low):
- PhyStatus=1, RxStatus=0, RxElecidle=1, cur_pd=2 (P1), cur_rate=0, req_err=0.
- FSM goes to RST_HOLD; the timer loads RESET_DLY.

FSM states: RST_HOLD, IDLE, PD_WAIT, RATE_WAIT, DET_WAIT, ACK.

RST_HOLD:
- PhyStatus held at 1 while the timer counts down.
- At count 0: PhyStatus=0 on the next cycle, go to IDLE.
- No requests are accepted in this state.

IDLE, evaluated each cycle with fixed priority:
1. Powerdown != cur_pd:
   - If Powerdown is reserved (>3): pulse req_err and stay in IDLE. The error pulses once per distinct illegal value, not every cycle.
   - Otherwise: latch target, go to PD_WAIT with PD_DLY.
2. Rate != cur_rate:
   - If Rate > MAX_RATE: pulse req_err (same once-per-value rule).
   - Else if cur_pd is P0 or P1: latch target, go to RATE_WAIT with RATE_DLY.
   - Else (P0s/P2): request stays pending and is not acted on.
3. TxDetectRx=1 and cur_pd=P1 and TxEelecIdle[0]=1: go to DET_WAIT with DETECT_DLY.
- TxDetectRx in any other power state is ignored.

Simultaneous requests:
- PowerDown is serviced first.
- Other requests remain pending; the MAC holds its inputs until it sees PhyStatus.

*_WAIT states:
- The timer counts to 0, then the FSM goes to ACK.
- On entry to ACK:
  - PD: cur_pd <= target.
  - RATE: cur_rate <= target.
  - DET: RxStatus <= rx_present ? 3'b011 : 3'b000.
- Delay parameter value 0 behaves as 1.

ACK:
- PhyStatus=1 for exactly one cycle.
- RxStatus is valid in that same cycle only, then returns to 0.
- Returns to IDLE.
- Before accepting a new TxDetectRx, the FSM requires TxDetectRx to be deasserted for at least one cycle.

RxElecidle:
- Registered; 1 unless cur_pd=P0 and rx_present=1.

Requests during a *_WAIT state:
- Changed inputs are not sampled; they are re-evaluated in IDLE.

Reset mid-operation:
- Asynchronous return to reset values and RST_HOLD; any pending target is discarded.

Request-to-PhyStatus latency:
- Exactly DLY+2 cycles: 1 accept cycle, DLY timer cycles, then the ACK cycle.

Decomposition:
- Shared package pipe_pkg:
  - pd_e enum (P0, P0S, P1, P2)
  - RXSTAT_DETECTED=3'b011 and RXSTAT_OK=3'b000
  - rate encodings GEN1..GEN5
  - FSM state typedef
- One natural sub-module: pipe_delay_timer.
  - 16-bit load/count-down timer.
  - Interface: load, load_val, done.
  - Instantiated once and shared by all states.

Test Plan:
1. Reset released at t0 -> PhyStatus=1 for 64 cycles, then 0; cur_pd=2, RxElecidle=1.
2. In P1, TxEelecIdle=4'hF, rx_present=1, TxDetectRx=1 -> after 26 cycles one-cycle PhyStatus with RxStatus=3'b011; repeat with rx_present=0 -> RxStatus=3'b000.
3. Powerdown 2->0 -> PhyStatus pulse 18 cycles later, cur_pd=0; with rx_present=1, RxElecidle falls the cycle after.
4. Powerdown 2->0 and Rate 0->3 in the same cycle:
   - PD pulse at 18 cycles.
   - Rate pulse 34 cycles after the next IDLE accept.
   - cur_rate=3.
5. Rate=7 (>MAX_RATE), and separately Powerdown=5 -> single req_err pulse each, no PhyStatus, cur_* unchanged.
6. Reset asserted mid RATE_WAIT -> PhyStatus=1 immediately, cur_rate=0; the pending rate is not applied after the new 64-cycle hold.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the PIPE PHY control responder.
//   pd_e     - PowerDown encodings (P0, P0s, P1, P2)
//   state_e  - responder FSM states
//   RXSTAT_* - RxStatus codes used by the responder
//   GEN1..5  - Rate encodings
//   dly_cycles() - maps a delay parameter to a timer load value (0 acts as 1)
package pipe_pkg;

  typedef enum logic [3:0] {
    P0  = 4'd0,
    P0S = 4'd1,
    P1  = 4'd2,
    P2  = 4'd3
  } pd_e;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_IDLE,
    ST_PD_WAIT,
    ST_RATE_WAIT,
    ST_DET_WAIT,
    ST_ACK
  } state_e;

  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  localparam logic [3:0] GEN1 = 4'd0;
  localparam logic [3:0] GEN2 = 4'd1;
  localparam logic [3:0] GEN3 = 4'd2;
  localparam logic [3:0] GEN4 = 4'd3;
  localparam logic [3:0] GEN5 = 4'd4;

  // A zero delay would never let the timer report done a cycle ahead, so it
  // is promoted to one cycle.
  function automatic logic [15:0] dly_cycles(input int unsigned dly);
    return (dly == 0) ? 16'd1 : dly[15:0];
  endfunction

endpackage

// File: rtl/pipe_delay_timer.sv
// pipe_delay_timer: 16-bit load / count-down timer shared by all FSM states.
//   clk      - clock
//   rst_n    - async active-low reset, loads RST_VAL
//   load     - load load_val this cycle
//   load_val - value loaded (number of cycles until done+1)
//   done     - high during the last counted cycle (count <= 1)
module pipe_delay_timer #(
  parameter logic [15:0] RST_VAL = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Done one count early so a load of N keeps the FSM in its wait state for
  // exactly N cycles.
  assign done = (r_cnt <= 16'd1);

endmodule

// File: rtl/pipe_phy_ctrl_responder.sv
// pipe_phy_ctrl_responder: PHY-side PIPE control responder. Answers MAC
// PowerDown / Rate / TxDetectRx requests with the PhyStatus handshake.
//   clk, reset (async active-low)
//   Powerdown, Rate, TxDetectRx, TxEelecIdle - MAC requests
//   rx_present  - far-end receiver present (environment)
//   PhyStatus, RxStatus, RxElecidle - PHY status back to the MAC
//   cur_pd, cur_rate - active power state / rate
//   req_err     - one-cycle pulse per distinct illegal request value
//
// state        | meaning
// ST_RST_HOLD  | PhyStatus held high for RESET_DLY cycles after reset
// ST_IDLE      | evaluate requests: PowerDown > Rate > receiver detect
// ST_PD_WAIT   | PowerDown change in progress
// ST_RATE_WAIT | Rate change in progress
// ST_DET_WAIT  | receiver detection in progress
// ST_ACK       | one-cycle PhyStatus pulse, RxStatus valid
module pipe_phy_ctrl_responder
  import pipe_pkg::*;
#(
  parameter int unsigned RESET_DLY  = 64,
  parameter int unsigned PD_DLY     = 16,
  parameter int unsigned RATE_DLY   = 32,
  parameter int unsigned DETECT_DLY = 24,
  parameter int unsigned MAX_RATE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Powerdown,
  input  logic [3:0] Rate,
  input  logic       TxDetectRx,
  input  logic [3:0] TxEelecIdle,
  input  logic       rx_present,
  output logic       PhyStatus,
  output logic [2:0] RxStatus,
  output logic       RxElecidle,
  output logic [3:0] cur_pd,
  output logic [3:0] cur_rate,
  output logic       req_err
);

  localparam logic [3:0] MAX_RATE_L = 4'(MAX_RATE);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cur_pd;
  logic [3:0]  r_cur_rate;
  logic [3:0]  r_target;
  logic [3:0]  r_bad_pd;
  logic [3:0]  r_bad_rate;
  logic [2:0]  r_rxstat;
  logic        r_rxei;
  logic        r_req_err;
  logic        r_det_armed;

  logic        w_tmr_load;
  logic [15:0] w_tmr_val;
  logic        w_tmr_done;
  logic        w_err_pd;
  logic        w_err_rate;
  logic        w_det_acc;
  logic        w_pd_bad;
  logic        w_rate_bad;
  logic        w_unused;

  assign w_pd_bad   = (Powerdown > 4'd3);
  assign w_rate_bad = (Rate > MAX_RATE_L);
  assign w_unused   = ^TxEelecIdle[3:1];

  pipe_delay_timer #(
    .RST_VAL (dly_cycles(RESET_DLY))
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = 16'd0;
    w_err_pd    = 1'b0;
    w_err_rate  = 1'b0;
    w_det_acc   = 1'b0;
    case (r_state)
      ST_RST_HOLD: begin
        if (w_tmr_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (Powerdown != r_cur_pd) begin
          if (w_pd_bad) begin
            // Only a newly seen illegal value is reported.
            w_err_pd = (Powerdown != r_bad_pd);
          end else begin
            w_state_nxt = ST_PD_WAIT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = dly_cycles(PD_DLY);
          end
        end else if (Rate != r_cur_rate) begin
          if (w_rate_bad) begin
            w_err_rate = (Rate != r_bad_rate);
          end else if (r_cur_pd == P0 || r_cur_pd == P1) begin
            w_state_nxt = ST_RATE_WAIT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = dly_cycles(RATE_DLY);
          end
          // In P0s/P2 a legal rate change stays pending.
        end else if (TxDetectRx && r_det_armed && r_cur_pd == P1 && TxEelecIdle[0]) begin
          w_state_nxt = ST_DET_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = dly_cycles(DETECT_DLY);
          w_det_acc   = 1'b1;
        end
      end
      ST_PD_WAIT, ST_RATE_WAIT, ST_DET_WAIT: begin
        if (w_tmr_done) w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RST_HOLD;
      r_cur_pd    <= P1;
      r_cur_rate  <= GEN1;
      r_target    <= 4'd0;
      r_bad_pd    <= 4'd0;
      r_bad_rate  <= 4'd0;
      r_rxstat    <= RXSTAT_OK;
      r_rxei      <= 1'b1;
      r_req_err   <= 1'b0;
      r_det_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_tmr_load) begin
        r_target <= (w_state_nxt == ST_PD_WAIT) ? Powerdown : Rate;
      end
      if (r_state == ST_PD_WAIT && w_tmr_done) r_cur_pd <= r_target;
      if (r_state == ST_RATE_WAIT && w_tmr_done) r_cur_rate <= r_target;
      // RxStatus is loaded on ACK entry only, so it is non-zero for one cycle.
      r_rxstat <= (r_state == ST_DET_WAIT && w_tmr_done && rx_present) ?
                  RXSTAT_DETECTED : RXSTAT_OK;
      r_rxei    <= !(r_cur_pd == P0 && rx_present);
      r_req_err <= w_err_pd | w_err_rate;
      // Remember the last illegal value; a legal value clears the memory so
      // a later return to the same illegal value is reported again.
      if (!w_pd_bad)     r_bad_pd <= 4'd0;
      else if (w_err_pd) r_bad_pd <= Powerdown;
      if (!w_rate_bad)     r_bad_rate <= 4'd0;
      else if (w_err_rate) r_bad_rate <= Rate;
      // A new detection needs TxDetectRx to drop for at least one cycle.
      if (!TxDetectRx)    r_det_armed <= 1'b1;
      else if (w_det_acc) r_det_armed <= 1'b0;
    end
  end

  assign PhyStatus  = (r_state == ST_RST_HOLD) || (r_state == ST_ACK);
  assign RxStatus   = r_rxstat;
  assign RxElecidle = r_rxei;
  assign cur_pd     = r_cur_pd;
  assign cur_rate   = r_cur_rate;
  assign req_err    = r_req_err;

endmodule

// File: tb/tb_pipe_phy_ctrl_responder.sv
module tb_pipe_phy_ctrl_responder;

  localparam int RESET_DLY  = 64;
  localparam int PD_DLY     = 16;
  localparam int RATE_DLY   = 32;
  localparam int DETECT_DLY = 24;
  localparam int MAX_RATE   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Powerdown = 4'd2;
  logic [3:0] Rate = 4'd0;
  logic       TxDetectRx = 1'b0;
  logic [3:0] TxEelecIdle = 4'hF;
  logic       rx_present = 1'b1;
  logic       PhyStatus;
  logic [2:0] RxStatus;
  logic       RxElecidle;
  logic [3:0] cur_pd;
  logic [3:0] cur_rate;
  logic       req_err;

  pipe_phy_ctrl_responder #(
    .RESET_DLY (RESET_DLY), .PD_DLY (PD_DLY), .RATE_DLY (RATE_DLY),
    .DETECT_DLY (DETECT_DLY), .MAX_RATE (MAX_RATE)
  ) dut (
    .clk (clk), .reset (reset), .Powerdown (Powerdown), .Rate (Rate),
    .TxDetectRx (TxDetectRx), .TxEelecIdle (TxEelecIdle), .rx_present (rx_present),
    .PhyStatus (PhyStatus), .RxStatus (RxStatus), .RxElecidle (RxElecidle),
    .cur_pd (cur_pd), .cur_rate (cur_rate), .req_err (req_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  rxs;
    logic [3:0]  pd;
    logic [3:0]  rate;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_q[$];
  exp_t        mon_e;
  int unsigned mon_c;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  model_pd = 4'd2;
  logic [3:0]  model_rate = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ack(input int unsigned c, input logic [2:0] rxs);
    exp_t e;
    e.cyc = c; e.rxs = rxs; e.pd = model_pd; e.rate = model_rate;
    exp_q.push_back(e);
  endfunction

  // Monitor: every PhyStatus pulse and req_err pulse must match the head of
  // its scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (PhyStatus) begin
        if (exp_q.size() == 0) chk("unexpected_phystatus", int'(PhyStatus), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ack_cycle", int'(cyc), int'(mon_e.cyc));
          chk("ack_rxstatus", int'(RxStatus), int'(mon_e.rxs));
          chk("ack_cur_pd", int'(cur_pd), int'(mon_e.pd));
          chk("ack_cur_rate", int'(cur_rate), int'(mon_e.rate));
        end
      end else begin
        chk("rxstatus_outside_ack", int'(RxStatus), 0);
      end
      if (req_err) begin
        if (err_q.size() == 0) chk("unexpected_req_err", int'(req_err), 0);
        else begin
          mon_c = err_q.pop_front();
          chk("req_err_cycle", int'(cyc), int'(mon_c));
        end
      end
    end
  end

  task automatic wait_acks(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || err_q.size() > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() > 0 || err_q.size() > 0) begin
      failures++;
      $display("FAIL ack_timeout pending_acks=%0d pending_errs=%0d required=0", exp_q.size(), err_q.size());
      exp_q.delete();
      err_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("rxelecidle", int'(RxElecidle), (model_pd == 4'd0 && rx_present) ? 0 : 1);
  endtask

  task automatic do_reset();
    int n;
    mon_en = 1'b0;
    reset = 1'b0;
    Powerdown = 4'd2; Rate = 4'd0; TxDetectRx = 1'b0; TxEelecIdle = 4'hF;
    exp_q.delete(); err_q.delete();
    model_pd = 4'd2; model_rate = 4'd0;
    #1;
    chk("rst_phystatus", int'(PhyStatus), 1);
    chk("rst_rxstatus", int'(RxStatus), 0);
    chk("rst_rxelecidle", int'(RxElecidle), 1);
    chk("rst_cur_pd", int'(cur_pd), 2);
    chk("rst_cur_rate", int'(cur_rate), 0);
    chk("rst_req_err", int'(req_err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n = 0;
    while (PhyStatus && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("reset_hold_cycles", n, RESET_DLY);
    chk("hold_cur_pd", int'(cur_pd), 2);
    chk("hold_cur_rate", int'(cur_rate), 0);
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic op_pd(input logic [3:0] np);
    int unsigned n0;
    int k;
    logic [3:0] old;
    old = model_pd;
    n0 = cyc;
    Powerdown = np;
    model_pd = np;
    push_ack(n0 + PD_DLY + 1, 3'b000);
    if (Rate != model_rate && Rate <= MAX_RATE && (np == 4'd0 || np == 4'd2)) begin
      model_rate = Rate;
      push_ack(n0 + PD_DLY + RATE_DLY + 3, 3'b000);
    end
    if (np == 4'd0 && old != 4'd0) begin
      k = 0;
      while (cyc < n0 + PD_DLY + 1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("rxelecidle_in_ack", int'(RxElecidle), 1);
      @(negedge clk);
      chk("rxelecidle_after_p0", int'(RxElecidle), rx_present ? 0 : 1);
    end
    wait_acks(200);
  endtask

  task automatic op_rate(input logic [3:0] nr);
    int unsigned n0;
    n0 = cyc;
    Rate = nr;
    model_rate = nr;
    push_ack(n0 + RATE_DLY + 1, 3'b000);
    wait_acks(200);
  endtask

  task automatic op_rate_pending();
    logic [3:0] nr;
    do nr = 4'($urandom_range(0, MAX_RATE)); while (nr == model_rate);
    Rate = nr;
    repeat (RATE_DLY + 8) @(negedge clk);
    chk("pending_rate_not_applied", int'(cur_rate), int'(model_rate));
    op_pd(($urandom_range(0, 1) == 0) ? 4'd0 : 4'd2);
  endtask

  task automatic op_det(input logic rx);
    int unsigned n0;
    rx_present = rx;
    TxEelecIdle = 4'($urandom_range(0, 15)) | 4'h1;
    TxDetectRx = 1'b1;
    n0 = cyc;
    push_ack(n0 + DETECT_DLY + 1, rx ? 3'b011 : 3'b000);
    wait_acks(200);
    TxDetectRx = 1'b0;
    @(negedge clk);
  endtask

  task automatic op_det_ignored();
    TxEelecIdle = (model_pd == 4'd2) ? 4'($urandom_range(0, 7)) << 1 : 4'hF;
    TxDetectRx = 1'b1;
    repeat (DETECT_DLY + 6) @(negedge clk);
    TxDetectRx = 1'b0;
    @(negedge clk);
  endtask

  task automatic op_bad_rate(input logic [3:0] r1);
    logic [3:0] r2;
    Rate = r1;
    err_q.push_back(cyc + 1);
    repeat (6) @(negedge clk);
    do r2 = 4'($urandom_range(MAX_RATE + 1, 15)); while (r2 == r1);
    Rate = r2;
    err_q.push_back(cyc + 1);
    repeat (6) @(negedge clk);
    Rate = model_rate;
    wait_acks(20);
    chk("bad_rate_cur_rate", int'(cur_rate), int'(model_rate));
    chk("bad_rate_cur_pd", int'(cur_pd), int'(model_pd));
  endtask

  task automatic op_bad_pd(input logic [3:0] p1);
    Powerdown = p1;
    err_q.push_back(cyc + 1);
    repeat (8) @(negedge clk);
    Powerdown = model_pd;
    wait_acks(20);
    chk("bad_pd_cur_pd", int'(cur_pd), int'(model_pd));
    chk("bad_pd_cur_rate", int'(cur_rate), int'(model_rate));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int sel;
    @(negedge clk);
    do_reset();

    op_det(1'b1);
    op_det(1'b0);

    rx_present = 1'b1;
    Rate = 4'd3;
    op_pd(4'd0);
    chk("simul_cur_rate", int'(cur_rate), 3);

    op_bad_rate(4'd7);
    op_bad_pd(4'd5);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin
          do v = 4'($urandom_range(0, 3)); while (v == model_pd);
          op_pd(v);
        end
        1, 6: begin
          if (model_pd == 4'd0 || model_pd == 4'd2) begin
            do v = 4'($urandom_range(0, MAX_RATE)); while (v == model_rate);
            op_rate(v);
          end else begin
            op_rate_pending();
          end
        end
        2: begin
          if (model_pd == 4'd2) op_det(1'($urandom_range(0, 1)));
          else op_det_ignored();
        end
        3: op_det_ignored();
        4: op_bad_rate(4'($urandom_range(MAX_RATE + 1, 15)));
        default: op_bad_pd(4'($urandom_range(4, 15)));
      endcase
    end

    if (model_pd != 4'd0 && model_pd != 4'd2) op_pd(4'd0);
    do v = 4'($urandom_range(0, MAX_RATE)); while (v == model_rate || v == 4'd0);
    Rate = v;
    repeat (10) @(negedge clk);
    do_reset();
    repeat (RATE_DLY + 10) @(negedge clk);
    chk("post_reset_cur_rate", int'(cur_rate), 0);
    chk("post_reset_cur_pd", int'(cur_pd), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
